// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: register-file geometry and the forwarding-select
// encodings that the EX-stage forwarding unit also uses.
package pipeline_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;
endpackage

// File: rtl/hazard_scoreboard_busy_table.sv
// Pending-write bitmap. One set port (long-op issue) and one clear port (long-op writeback).
// x0 never reads as busy.
module busy_table
  import pipeline_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_set,
  input  logic [REG_ADDR_W-1:0] i_set_addr,
  input  logic                  i_clr,
  input  logic [REG_ADDR_W-1:0] i_clr_addr,
  output logic [NUM_REGS-1:0]   o_busy
);
  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_set_mask;
  logic [NUM_REGS-1:0] w_clr_mask;
  logic [NUM_REGS-1:0] w_next;

  assign w_set_mask = i_set ? (NUM_REGS'(1) << i_set_addr) : '0;
  assign w_clr_mask = i_clr ? (NUM_REGS'(1) << i_clr_addr) : '0;
  // The clear is applied first, so a set to the same register takes priority.
  assign w_next     = (r_busy & ~w_clr_mask) | w_set_mask;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= {w_next[NUM_REGS-1:1], 1'b0};
    end
  end

  assign o_busy = r_busy;
endmodule

// File: rtl/hazard_scoreboard.sv
// Issue-side hazard controller: stalls ID on load-use, on pending long-op results (RAW/WAW)
// and on long-op unit capacity; tracks in-flight long ops and counts stall cycles.
module hazard_scoreboard
  import pipeline_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_is_long,
  input  logic                  id_flush,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  lo_done,
  input  logic [REG_ADDR_W-1:0] lo_rd,
  output logic                  stall,
  output logic                  bubble,
  output logic                  long_issue,
  output logic [NUM_REGS-1:0]   busy,
  output logic [3:0]            outstanding,
  output logic                  sb_error,
  output logic [CNT_W-1:0]      stall_cycles
);
  localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

  logic [NUM_REGS-1:0] w_busy;
  logic [3:0]          r_outstanding;
  logic                r_sb_error;
  logic [CNT_W-1:0]    r_stall_cycles;

  logic w_src1_hit, w_src2_hit, w_waw_hit;
  logic w_lu_hz, w_lo_hz, w_cap_hz;
  logic w_go, w_stall, w_long_issue, w_clr_idle;

  assign w_src1_hit = id_uses_rs1 & (id_rs1 != '0) & w_busy[id_rs1];
  assign w_src2_hit = id_uses_rs2 & (id_rs2 != '0) & w_busy[id_rs2];
  assign w_waw_hit  = id_reg_write & (id_rd != '0) & w_busy[id_rd];

  assign w_lu_hz  = ex_mem_read & (ex_rd != '0) &
                    (((ex_rd == id_rs1) & id_uses_rs1) | ((ex_rd == id_rs2) & id_uses_rs2));
  assign w_lo_hz  = w_src1_hit | w_src2_hit | w_waw_hit;
  assign w_cap_hz = id_is_long & (r_outstanding == MAX_OUT);

  // A flushed ID slot is dead: it neither stalls nor claims a destination.
  assign w_go         = id_valid & ~id_flush;
  assign w_stall      = w_go & (w_lu_hz | w_lo_hz | w_cap_hz);
  assign w_long_issue = w_go & ~w_stall & id_is_long;
  assign w_clr_idle   = lo_done & (lo_rd != '0) & ~w_busy[lo_rd];

  busy_table u_busy_table (
    .clk        (clk),
    .reset      (reset),
    .i_set      (w_long_issue & (id_rd != '0)),
    .i_set_addr (id_rd),
    .i_clr      (lo_done),
    .i_clr_addr (lo_rd),
    .o_busy     (w_busy)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_outstanding  <= '0;
      r_sb_error     <= 1'b0;
      r_stall_cycles <= '0;
    end else begin
      // Issue and completion in the same cycle cancel out.
      if (w_long_issue & ~lo_done) begin
        if (r_outstanding != MAX_OUT) r_outstanding <= r_outstanding + 4'd1;
      end else if (lo_done & ~w_long_issue) begin
        if (r_outstanding != 4'd0) r_outstanding <= r_outstanding - 4'd1;
        else                       r_sb_error    <= 1'b1;
      end
      if (w_clr_idle) r_sb_error <= 1'b1;
      if (w_stall && (r_stall_cycles != '1)) r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

  assign stall        = w_stall;
  assign bubble       = w_stall;
  assign long_issue   = w_long_issue;
  assign busy         = w_busy;
  assign outstanding  = r_outstanding;
  assign sb_error     = r_sb_error;
  assign stall_cycles = r_stall_cycles;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus randomized traffic
// checked against a register-set / counter reference model.
module tb_hazard_scoreboard;
  localparam int MAXO = 4;
  localparam int CW   = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_uses_rs1, id_uses_rs2, id_reg_write, id_is_long, id_flush;
  logic [4:0] id_rs1, id_rs2, id_rd, ex_rd, lo_rd;
  logic       ex_mem_read, lo_done;
  logic       stall, bubble, long_issue, sb_error;
  logic [31:0] busy;
  logic [3:0]  outstanding;
  logic [CW-1:0] stall_cycles;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: set of registers awaiting a long-op result, ops in flight,
  // sticky error flag, stall counter.
  bit m_busy[32];
  int m_out;
  bit m_err;
  int m_cnt;

  always #5 clk = ~clk;

  hazard_scoreboard #(.MAX_OUTSTANDING(MAXO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_is_long(id_is_long), .id_flush(id_flush),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .lo_done(lo_done), .lo_rd(lo_rd),
    .stall(stall), .bubble(bubble), .long_issue(long_issue), .busy(busy),
    .outstanding(outstanding), .sb_error(sb_error), .stall_cycles(stall_cycles)
  );

  function automatic bit m_stall();
    bit lu, lo, cap;
    lu  = ex_mem_read && ex_rd != 0 &&
          ((ex_rd == id_rs1 && id_uses_rs1) || (ex_rd == id_rs2 && id_uses_rs2));
    lo  = (id_uses_rs1 && m_busy[id_rs1]) || (id_uses_rs2 && m_busy[id_rs2]) ||
          (id_reg_write && m_busy[id_rd]);
    cap = id_is_long && m_out == MAXO;
    return id_valid && !id_flush && (lu || lo || cap);
  endfunction

  function automatic bit m_issue();
    return id_valid && !id_flush && !m_stall() && id_is_long;
  endfunction

  function automatic logic [31:0] m_busy_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic idle();
    reset = 0; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    id_rd = 0; id_reg_write = 0; id_is_long = 0; id_flush = 0;
    ex_mem_read = 0; ex_rd = 0; lo_done = 0; lo_rd = 0;
  endtask

  // Advance one clock edge and apply the same edge to the model.
  task automatic tick();
    bit s, iss;
    s = m_stall(); iss = m_issue();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 0;
      m_out = 0; m_err = 0; m_cnt = 0;
    end else begin
      if (lo_done) begin
        if (!m_busy[lo_rd] && lo_rd != 0) m_err = 1;
        m_busy[lo_rd] = 0;
      end
      if (iss && id_rd != 0) m_busy[id_rd] = 1;
      if (iss && !lo_done && m_out < MAXO) m_out++;
      if (lo_done && !iss) begin
        if (m_out > 0) m_out--; else m_err = 1;
      end
      if (s && m_cnt < (1 << CW) - 1) m_cnt++;
    end
    #1;
  endtask

  task automatic issue_long(input logic [4:0] rd);
    idle(); id_valid = 1; id_is_long = 1; id_reg_write = 1; id_rd = rd;
    tick();
  endtask

  task automatic test_reset();
    idle(); reset = 1; tick(); reset = 0; #1;
    n_total++; if (busy !== 32'h0) $display("FAIL rst_busy: got %h want 0", busy); else n_pass++;
    n_total++; if (outstanding !== 4'd0) $display("FAIL rst_out: got %0d want 0", outstanding); else n_pass++;
    n_total++; if (sb_error !== 1'b0) $display("FAIL rst_err: got %0b want 0", sb_error); else n_pass++;
    n_total++; if (stall_cycles !== '0) $display("FAIL rst_cnt: got %0d want 0", stall_cycles); else n_pass++;
    ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1; id_is_long = 1; #1;
    n_total++; if ({stall, bubble, long_issue} !== 3'b000)
      $display("FAIL invalid_quiet: got %b want 000", {stall, bubble, long_issue}); else n_pass++;
    tick();
  endtask

  task automatic test_load_use();
    idle(); id_valid = 1; id_rs1 = 5; id_uses_rs1 = 1; ex_mem_read = 1; ex_rd = 5; #1;
    n_total++; if ({stall, bubble} !== 2'b11) $display("FAIL lu_stall: got %b want 11", {stall, bubble}); else n_pass++;
    tick();
    ex_mem_read = 0; ex_rd = 0; #1;
    n_total++; if ({stall, bubble} !== 2'b00) $display("FAIL lu_release: got %b want 00", {stall, bubble}); else n_pass++;
    tick();
    n_total++; if (stall_cycles !== CW'(1)) $display("FAIL lu_cnt: got %0d want 1", stall_cycles); else n_pass++;
  endtask

  task automatic test_long_op();
    idle(); id_valid = 1; id_is_long = 1; id_reg_write = 1; id_rd = 7; #1;
    n_total++; if (long_issue !== 1'b1) $display("FAIL div_issue: got %0b want 1", long_issue); else n_pass++;
    tick();
    n_total++; if (busy[7] !== 1'b1 || outstanding !== 4'd1)
      $display("FAIL div_busy: got busy7=%0b out=%0d want 1/1", busy[7], outstanding); else n_pass++;
    idle(); id_valid = 1; id_rs2 = 7; id_uses_rs2 = 1; id_rd = 8; id_reg_write = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++; if (stall !== 1'b1) $display("FAIL raw_wait%0d: got %0b want 1", i, stall); else n_pass++;
      tick();
    end
    lo_done = 1; lo_rd = 7; #1;
    n_total++; if (stall !== 1'b1) $display("FAIL raw_done_cycle: got %0b want 1", stall); else n_pass++;
    tick();
    lo_done = 0; lo_rd = 0; #1;
    n_total++; if (stall !== 1'b0) $display("FAIL raw_release: got %0b want 0", stall); else n_pass++;
    n_total++; if (busy[7] !== 1'b0 || outstanding !== 4'd0)
      $display("FAIL div_clear: got busy7=%0b out=%0d want 0/0", busy[7], outstanding); else n_pass++;
    tick();
  endtask

  task automatic test_capacity();
    for (int r = 1; r <= 4; r++) issue_long(5'(r));
    n_total++; if (outstanding !== 4'd4) $display("FAIL cap_full: got %0d want 4", outstanding); else n_pass++;
    idle(); id_valid = 1; id_is_long = 1; id_reg_write = 1; id_rd = 5; #1;
    n_total++; if ({stall, long_issue} !== 2'b10) $display("FAIL cap_stall: got %b want 10", {stall, long_issue}); else n_pass++;
    tick();
    lo_done = 1; lo_rd = 2; #1;
    n_total++; if (stall !== 1'b1) $display("FAIL cap_done_cycle: got %0b want 1", stall); else n_pass++;
    tick();
    lo_done = 0; lo_rd = 0; #1;
    n_total++; if ({stall, long_issue} !== 2'b01) $display("FAIL cap_issue: got %b want 01", {stall, long_issue}); else n_pass++;
    tick();
    n_total++; if (outstanding !== 4'd4 || busy !== 32'h0000_003A)
      $display("FAIL cap_after: got out=%0d busy=%h want 4/0000003a", outstanding, busy); else n_pass++;
    idle();
    for (int r = 1; r <= 5; r++) begin
      if (r != 2) begin lo_done = 1; lo_rd = 5'(r); tick(); end
    end
    idle(); #1;
    n_total++; if (outstanding !== 4'd0 || busy !== 32'h0 || sb_error !== 1'b0)
      $display("FAIL cap_drain: got out=%0d busy=%h err=%0b want 0/0/0", outstanding, busy, sb_error); else n_pass++;
  endtask

  task automatic test_x0_flush();
    issue_long(5'd0);
    n_total++; if (busy !== 32'h0 || outstanding !== 4'd1)
      $display("FAIL x0_issue: got busy=%h out=%0d want 0/1", busy, outstanding); else n_pass++;
    idle(); lo_done = 1; lo_rd = 0; tick(); idle();
    n_total++; if (outstanding !== 4'd0 || sb_error !== 1'b0)
      $display("FAIL x0_done: got out=%0d err=%0b want 0/0", outstanding, sb_error); else n_pass++;
    id_valid = 1; id_flush = 1; id_rs1 = 3; id_uses_rs1 = 1; ex_mem_read = 1; ex_rd = 3;
    id_is_long = 1; id_reg_write = 1; id_rd = 6; #1;
    n_total++; if ({stall, bubble, long_issue} !== 3'b000)
      $display("FAIL flush_quiet: got %b want 000", {stall, bubble, long_issue}); else n_pass++;
    tick();
    n_total++; if (busy !== 32'h0 || outstanding !== 4'd0)
      $display("FAIL flush_state: got busy=%h out=%0d want 0/0", busy, outstanding); else n_pass++;
    idle();
  endtask

  task automatic test_error_reset();
    idle(); lo_done = 1; lo_rd = 9; tick(); idle();
    n_total++; if (sb_error !== 1'b1) $display("FAIL err_set: got %0b want 1", sb_error); else n_pass++;
    tick(); tick();
    n_total++; if (sb_error !== 1'b1) $display("FAIL err_sticky: got %0b want 1", sb_error); else n_pass++;
    issue_long(5'd10); issue_long(5'd11); issue_long(5'd12);
    idle(); reset = 1; tick(); reset = 0; #1;
    n_total++; if (busy !== 32'h0 || outstanding !== 4'd0 || sb_error !== 1'b0 || stall_cycles !== '0)
      $display("FAIL mid_reset: got busy=%h out=%0d err=%0b cnt=%0d want all 0",
               busy, outstanding, sb_error, stall_cycles); else n_pass++;
    lo_done = 1; lo_rd = 10; tick(); idle();
    n_total++; if (sb_error !== 1'b1) $display("FAIL stale_done: got %0b want 1", sb_error); else n_pass++;
    reset = 1; tick(); reset = 0;
  endtask

  task automatic test_random();
    bit exp_s, exp_i;
    int cand[$];
    for (int n = 0; n < 400; n++) begin
      idle();
      id_valid     = ($urandom_range(0, 3) != 0);
      id_rs1       = 5'($urandom_range(0, 7));
      id_rs2       = 5'($urandom_range(0, 7));
      id_rd        = 5'($urandom_range(0, 7));
      id_uses_rs1  = 1'($urandom_range(0, 1));
      id_uses_rs2  = 1'($urandom_range(0, 1));
      id_reg_write = 1'($urandom_range(0, 1));
      id_is_long   = ($urandom_range(0, 2) == 0);
      id_flush     = ($urandom_range(0, 9) == 0);
      ex_mem_read  = ($urandom_range(0, 3) == 0);
      ex_rd        = 5'($urandom_range(0, 7));
      if (m_out > 0 && $urandom_range(0, 2) == 0) begin
        cand.delete();
        for (int r = 1; r < 32; r++) if (m_busy[r]) cand.push_back(r);
        lo_done = 1;
        lo_rd   = (cand.size() > 0) ? 5'(cand[$urandom_range(0, cand.size() - 1)]) : 5'd0;
        if ($urandom_range(0, 19) == 0) lo_rd = 5'($urandom_range(0, 31));
      end
      #1;
      exp_s = m_stall(); exp_i = m_issue();
      n_total++; if (stall !== exp_s) $display("FAIL rnd_stall[%0d]: got %0b want %0b", n, stall, exp_s); else n_pass++;
      n_total++; if (bubble !== exp_s) $display("FAIL rnd_bubble[%0d]: got %0b want %0b", n, bubble, exp_s); else n_pass++;
      n_total++; if (long_issue !== exp_i) $display("FAIL rnd_issue[%0d]: got %0b want %0b", n, long_issue, exp_i); else n_pass++;
      tick();
      n_total++; if (busy !== m_busy_vec()) $display("FAIL rnd_busy[%0d]: got %h want %h", n, busy, m_busy_vec()); else n_pass++;
      n_total++; if (outstanding !== 4'(m_out)) $display("FAIL rnd_out[%0d]: got %0d want %0d", n, outstanding, m_out); else n_pass++;
      n_total++; if (sb_error !== m_err) $display("FAIL rnd_err[%0d]: got %0b want %0b", n, sb_error, m_err); else n_pass++;
      n_total++; if (stall_cycles !== CW'(m_cnt)) $display("FAIL rnd_cnt[%0d]: got %0d want %0d", n, stall_cycles, m_cnt); else n_pass++;
    end
  endtask

  initial begin
    idle();
    for (int i = 0; i < 32; i++) m_busy[i] = 0;
    m_out = 0; m_err = 0; m_cnt = 0;
    @(posedge clk); #1;
    test_reset();
    test_load_use();
    test_long_op();
    test_capacity();
    test_x0_flush();
    test_error_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
